// File: rtl/mux_sched_pkg.sv
// ---------------------------------------------------------------------------
// mux_sched_pkg
// Shared definitions for the mux scheduler family: grant FSM state encoding,
// requester count / select width, and a one-hot encoder for a select index.
// No ports (package).
// ---------------------------------------------------------------------------
package mux_sched_pkg;

   localparam int NUM_REQ = 16;
   localparam int SEL_W   = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [NUM_REQ-1:0] ONE_REQ = 16'h0001;

   // One-hot encoding of a select index: bit idx set, all others clear.
   function automatic logic [NUM_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
      return ONE_REQ << idx;
   endfunction

endpackage

// File: rtl/rr_pick16.sv
// ---------------------------------------------------------------------------
// rr_pick16
// Combinational rotating-priority finder. Returns the first set request bit
// found scanning upward from index ptr, wrapping 15 -> 0.
// Ports:
//   req [15:0] in  : request vector
//   ptr [3:0]  in  : index with highest priority this scan
//   any        out : at least one request bit set
//   idx [3:0]  out : winning index (0 when any is low)
// ---------------------------------------------------------------------------
module rr_pick16
   import mux_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               any,
   output logic [SEL_W-1:0]   idx
);

   logic [NUM_REQ-1:0] rot_s;
   logic [SEL_W-1:0]   off_s;

   // Rotate the request vector so that bit 0 corresponds to index ptr; the
   // 4-bit index addition wraps naturally modulo 16.
   always_comb begin
      rot_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rot_s[i] = req[ptr + SEL_W'(i)];
      end
   end

   // Lowest set bit of the rotated vector is the distance from ptr to the
   // winner; scanning downward lets the lowest hit overwrite higher ones.
   always_comb begin
      off_s = 4'd0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot_s[i]) begin
            off_s = SEL_W'(i);
         end else begin
            off_s = off_s;
         end
      end
   end

   // Undo the rotation to get the absolute winner index.
   always_comb begin
      any = |req;
      if (any) begin
         idx = ptr + off_s;
      end else begin
         idx = 4'd0;
      end
   end

endmodule

// File: rtl/mux16_rr_sched.sv
// ---------------------------------------------------------------------------
// mux16_rr_sched
// Round-robin scheduler owning the select of a 16:1 bit mux. One requester at
// a time is granted; the grant ends on request drop, a done pulse, or after
// MAX_HOLD cycles. At least one idle cycle separates consecutive grants.
// Ports:
//   clk            in  : clock, rising edge
//   rst            in  : synchronous active-high reset
//   en             in  : allow new grants to start
//   req [15:0]     in  : request vector
//   done           in  : owner's early-release pulse
//   sel [3:0]      out : registered mux select (current/last winner)
//   gnt_valid      out : grant active
//   gnt [15:0]     out : one-hot grant, zero when no grant is active
//   timeout        out : grant is being ended this cycle by the hold limit
// Parameters:
//   MAX_HOLD (1..255) maximum grant length; CNT_W with 2^CNT_W > MAX_HOLD.
// ---------------------------------------------------------------------------
module mux16_rr_sched #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] req,
   input  logic        done,
   output logic [3:0]  sel,
   output logic        gnt_valid,
   output logic [15:0] gnt,
   output logic        timeout
);

   import mux_sched_pkg::*;

   state_t             state_r,     state_nxt_s;
   logic [SEL_W-1:0]   sel_r,       sel_nxt_s;
   logic               gv_r,        gv_nxt_s;
   logic [NUM_REQ-1:0] gnt_r,       gnt_nxt_s;
   logic [SEL_W-1:0]   ptr_r,       ptr_nxt_s;
   logic [CNT_W-1:0]   cnt_r,       cnt_nxt_s;

   logic               pick_any_s;
   logic [SEL_W-1:0]   pick_idx_s;
   logic               hold_last_s;
   logic               owner_req_s;
   logic               release_s;

   rr_pick16 u_pick (
      .req (req),
      .ptr (ptr_r),
      .any (pick_any_s),
      .idx (pick_idx_s)
   );

   // Release conditions for the active grant. hold_last_s marks the final
   // permitted cycle, so cnt never needs to reach MAX_HOLD.
   always_comb begin
      hold_last_s = (cnt_r == CNT_W'(MAX_HOLD - 1));
      owner_req_s = req[sel_r];
      release_s   = (!owner_req_s) || done || hold_last_s;
   end

   // Next-state and next-output logic of the grant FSM.
   always_comb begin
      state_nxt_s = state_r;
      sel_nxt_s   = sel_r;
      gv_nxt_s    = gv_r;
      gnt_nxt_s   = gnt_r;
      ptr_nxt_s   = ptr_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (en && pick_any_s) begin
               state_nxt_s = GRANT;
               sel_nxt_s   = pick_idx_s;
               gv_nxt_s    = 1'b1;
               gnt_nxt_s   = onehot16(pick_idx_s);
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         GRANT: begin
            if (release_s) begin
               // Pointer moves past the winner so it gets lowest priority next.
               state_nxt_s = IDLE;
               gv_nxt_s    = 1'b0;
               gnt_nxt_s   = '0;
               ptr_nxt_s   = sel_r + 4'd1;
               cnt_nxt_s   = '0;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_nxt_s = IDLE;
            gv_nxt_s    = 1'b0;
            gnt_nxt_s   = '0;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         sel_r   <= 4'd0;
         gv_r    <= 1'b0;
         gnt_r   <= 16'h0000;
         ptr_r   <= 4'd0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         sel_r   <= sel_nxt_s;
         gv_r    <= gv_nxt_s;
         gnt_r   <= gnt_nxt_s;
         ptr_r   <= ptr_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // timeout flags the release cycle itself, so it decodes registered state
   // with this cycle's req/done; a voluntary release suppresses it.
   always_comb begin
      if ((state_r == GRANT) && hold_last_s && owner_req_s && !done) begin
         timeout = 1'b1;
      end else begin
         timeout = 1'b0;
      end
   end

   assign sel       = sel_r;
   assign gnt_valid = gv_r;
   assign gnt       = gnt_r;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_mux16_rr_sched
// Scoreboard bench: the driver applies inputs, advances an abstract model of
// the scheduler and queues the expected outputs; a monitor on the falling
// edge pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_mux16_rr_sched;

   localparam int MH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] req;
   logic        done;
   logic [3:0]  sel;
   logic        gnt_valid;
   logic [15:0] gnt;
   logic        timeout;

   typedef struct packed {
      logic [3:0]  sel;
      logic        gv;
      logic [15:0] gnt;
      logic        to;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   // abstract model state
   int   m_busy = 0;
   int   m_sel  = 0;
   int   m_ptr  = 0;
   int   m_held = 0;

   mux16_rr_sched #(.MAX_HOLD(MH), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .done      (done),
      .sel       (sel),
      .gnt_valid (gnt_valid),
      .gnt       (gnt),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   // Advance the model by one clock edge using the inputs present at it.
   task automatic model_edge();
      if (rst) begin
         m_busy = 0; m_sel = 0; m_ptr = 0; m_held = 0;
      end else if (m_busy == 0) begin
         if (en && req != 16'h0000) begin
            for (int k = 0; k < 16; k++) begin
               if (req[(m_ptr + k) % 16]) begin
                  m_sel = (m_ptr + k) % 16;
                  break;
               end
            end
            m_busy = 1;
            m_held = 0;
         end
      end else if (!req[m_sel] || done || m_held == MH - 1) begin
         m_busy = 0;
         m_ptr  = (m_sel + 1) % 16;
      end else begin
         m_held = m_held + 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Drive inputs for this cycle and queue what the DUT must show.
   task automatic apply(input logic r, input logic e_in, input logic [15:0] rq, input logic d);
      exp_t x;
      rst = r; en = e_in; req = rq; done = d;
      x.sel = 4'(m_sel);
      x.gv  = (m_busy != 0);
      x.gnt = (m_busy != 0) ? (16'h0001 << m_sel) : 16'h0000;
      x.to  = (m_busy != 0) && (m_held == MH - 1) && rq[m_sel] && !d;
      q.push_back(x);
   endtask

   // Monitor: compare DUT outputs with the oldest queued expectation.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         checks = checks + 1;
         if (sel !== e.sel) begin
            errors = errors + 1;
            $display("FAIL sel: got %0d expected %0d at %0t", sel, e.sel, $time);
         end
         checks = checks + 1;
         if (gnt_valid !== e.gv) begin
            errors = errors + 1;
            $display("FAIL gnt_valid: got %b expected %b at %0t", gnt_valid, e.gv, $time);
         end
         checks = checks + 1;
         if (gnt !== e.gnt) begin
            errors = errors + 1;
            $display("FAIL gnt: got %h expected %h at %0t", gnt, e.gnt, $time);
         end
         checks = checks + 1;
         if (timeout !== e.to) begin
            errors = errors + 1;
            $display("FAIL timeout: got %b expected %b at %0t", timeout, e.to, $time);
         end
      end
   end

   initial begin
      logic [15:0] rnd_req;
      rst = 1'b1; en = 1'b0; req = 16'h0000; done = 1'b0;

      // reset with all requesting, then first grant goes to 0
      tick(); apply(1'b1, 1'b1, 16'hFFFF, 1'b0);
      tick(); apply(1'b1, 1'b1, 16'hFFFF, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick(); apply(1'b0, 1'b1, 16'hFFFF, 1'b0);
      end

      // rotation between 0 and 4, done pulsed while granted
      tick(); apply(1'b1, 1'b1, 16'h0011, 1'b0);
      for (int i = 0; i < 14; i++) begin
         tick(); apply(1'b0, 1'b1, 16'h0011, logic'(m_busy != 0));
      end

      // wrap-around: grant 14, then 15, then 0
      tick(); apply(1'b1, 1'b1, 16'h4000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(); apply(1'b0, 1'b1, 16'h4000, logic'(m_busy != 0));
      end
      for (int i = 0; i < 6; i++) begin
         tick(); apply(1'b0, 1'b1, 16'h8001, logic'(m_busy != 0));
      end

      // timeout with a single held requester
      tick(); apply(1'b1, 1'b1, 16'h0020, 1'b0);
      for (int i = 0; i < 22; i++) begin
         tick(); apply(1'b0, 1'b1, 16'h0020, 1'b0);
      end

      // req drop together with done on the last permitted cycle
      tick(); apply(1'b1, 1'b1, 16'h0008, 1'b0);
      for (int i = 0; i < 12; i++) begin
         tick();
         if (m_busy != 0 && m_held == MH - 1) begin
            apply(1'b0, 1'b1, 16'h0000, 1'b1);
         end else if (m_busy == 0 && m_ptr == 4) begin
            apply(1'b0, 1'b1, 16'hFFFF, 1'b0);
         end else begin
            apply(1'b0, 1'b1, 16'h0008, 1'b0);
         end
      end

      // enable gating, then reset in the middle of a grant
      tick(); apply(1'b1, 1'b1, 16'h0000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick(); apply(1'b0, 1'b0, 16'h0100, 1'b0);
      end
      tick(); apply(1'b0, 1'b1, 16'h0100, 1'b0);
      tick(); apply(1'b0, 1'b0, 16'h0100, 1'b0);
      tick(); apply(1'b1, 1'b0, 16'h0100, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(); apply(1'b0, 1'b1, 16'hFFFF, 1'b0);
      end

      // randomized traffic; req changes occasionally so holds reach the limit
      rnd_req = 16'(($urandom & 32'hFFFF) & ($urandom & 32'hFFFF));
      for (int i = 0; i < 3000; i++) begin
         tick();
         if ($urandom_range(0, 7) == 0) begin
            rnd_req = 16'(($urandom & 32'hFFFF) & ($urandom & 32'hFFFF));
         end
         apply(logic'($urandom_range(0, 99) == 0),
               logic'($urandom_range(0, 7) != 0),
               rnd_req,
               logic'($urandom_range(0, 9) == 0));
      end

      tick();
      @(negedge clk);
      #1;
      checks = checks + 1;
      if (q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
